// File: rtl/pipeline_pkg.sv
// Shared decode->execute control types: ALU op width, control bundle and its bubble value.
// Pure types/constants; no timing or flow control.
package pipeline_pkg;

  localparam int ALUCTL_W_DEF = 3;

  typedef logic [ALUCTL_W_DEF-1:0] alucontrol_t;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        branch;
    logic        alusrc;
    logic        regdst;
    alucontrol_t alucontrol;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit stage flop: 1-cycle latency, holds when en_i=0, sync clear beats enable.
// Async active-low reset to zero.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)     q_d = '0;
    else if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX stage register: 1-cycle latency; stallE holds, flushE inserts a bubble (flush beats stall).
// Define ID_EX_PERF_CNT_EN to add saturating stall/flush counters and their ports.
module id_ex_pipe_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int ALUCTL_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stallE,
  input  logic                flushE,
  input  logic                validD,
  input  logic [DATA_W-1:0]   rd1D,
  input  logic [DATA_W-1:0]   rd2D,
  input  logic [REG_W-1:0]    RsD,
  input  logic [REG_W-1:0]    RtD,
  input  logic [REG_W-1:0]    RdD,
  input  logic [DATA_W-1:0]   signimmD,
  input  logic                regwriteD,
  input  logic                memtoregD,
  input  logic                memwriteD,
  input  logic                branchD,
  input  logic                alusrcD,
  input  logic                regdstD,
  input  logic [ALUCTL_W-1:0] alucontrolD,
  output logic                validE,
  output logic [DATA_W-1:0]   rd1E,
  output logic [DATA_W-1:0]   rd2E,
  output logic [DATA_W-1:0]   signimmE,
  output logic [REG_W-1:0]    RsE,
  output logic [REG_W-1:0]    RtE,
  output logic [REG_W-1:0]    RdE,
  output logic                regwriteE,
  output logic                memtoregE,
  output logic                memwriteE,
  output logic                branchE,
  output logic                alusrcE,
  output logic                regdstE,
  output logic [ALUCTL_W-1:0] alucontrolE
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
`endif
);

  localparam int DW = 3*DATA_W + 3*REG_W;
  localparam int CW = $bits(ctrl_t) + 1;

  ctrl_t         ctrl_d;
  ctrl_t         ctrl_e;
  logic [DW-1:0] data_q;
  logic [CW-1:0] ctrl_q;

  // Invalid slots are stripped of side effects here so a bubble can never write or branch.
  always_comb begin
    ctrl_d            = CTRL_BUBBLE;
    ctrl_d.regwrite   = regwriteD & validD;
    ctrl_d.memtoreg   = memtoregD;
    ctrl_d.memwrite   = memwriteD & validD;
    ctrl_d.branch     = branchD & validD;
    ctrl_d.alusrc     = alusrcD;
    ctrl_d.regdst     = regdstD;
    ctrl_d.alucontrol = alucontrol_t'(alucontrolD);
  end

  pipe_reg #(.W(DW)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (~stallE),
    .clr_i (flushE),
    .d_i   ({rd1D, rd2D, signimmD, RsD, RtD, RdD}),
    .q_o   (data_q)
  );

  pipe_reg #(.W(CW)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (~stallE),
    .clr_i (flushE),
    .d_i   ({validD, ctrl_d}),
    .q_o   (ctrl_q)
  );

  assign {rd1E, rd2E, signimmE, RsE, RtE, RdE} = data_q;
  assign {validE, ctrl_e} = ctrl_q;

  assign regwriteE   = ctrl_e.regwrite;
  assign memtoregE   = ctrl_e.memtoreg;
  assign memwriteE   = ctrl_e.memwrite;
  assign branchE     = ctrl_e.branch;
  assign alusrcE     = ctrl_e.alusrc;
  assign regdstE     = ctrl_e.regdst;
  assign alucontrolE = ALUCTL_W'(ctrl_e.alucontrol);

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallE && !flushE && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flushE && flush_cnt_q != CNT_MAX)            flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  a_bubble_no_side_effects: assert property (@(posedge clk) disable iff (!rst_n)
    !validE |-> !(regwriteE || memwriteE || branchE));

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, load, stall, flush priority, bubble gating, counters.
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam int ALUCTL_W = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic stallE, flushE, validD;
  logic [DATA_W-1:0] rd1D, rd2D, signimmD;
  logic [REG_W-1:0] RsD, RtD, RdD;
  logic regwriteD, memtoregD, memwriteD, branchD, alusrcD, regdstD;
  logic [ALUCTL_W-1:0] alucontrolD;
  logic validE;
  logic [DATA_W-1:0] rd1E, rd2E, signimmE;
  logic [REG_W-1:0] RsE, RtE, RdE;
  logic regwriteE, memtoregE, memwriteE, branchE, alusrcE, regdstE;
  logic [ALUCTL_W-1:0] alucontrolE;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .ALUCTL_W(ALUCTL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE), .validD(validD),
    .rd1D(rd1D), .rd2D(rd2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .signimmD(signimmD),
    .regwriteD(regwriteD), .memtoregD(memtoregD), .memwriteD(memwriteD), .branchD(branchD),
    .alusrcD(alusrcD), .regdstD(regdstD), .alucontrolD(alucontrolD),
    .validE(validE), .rd1E(rd1E), .rd2E(rd2E), .signimmE(signimmE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE), .branchE(branchE),
    .alusrcE(alusrcE), .regdstE(regdstE), .alucontrolE(alucontrolE)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr;
    validD = 1'b1; rd1D = 32'h0000_1234; rd2D = 32'hA5A5_0001; signimmD = 32'hFFFF_FFF0;
    RsD = 5'd3; RtD = 5'd4; RdD = 5'd5;
    regwriteD = 1'b1; memtoregD = 1'b1; memwriteD = 1'b0; branchD = 1'b0;
    alusrcD = 1'b1; regdstD = 1'b1; alucontrolD = 3'b010;
  endtask

  task automatic test_reset;
    stallE = 0; flushE = 0;
    drive_instr();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({validE, rd1E, RsE, regwriteE, alucontrolE} !== '0) begin
      fails++; $display("FAIL reset_initial: got valid=%b rd1=%h rs=%0d", validE, rd1E, RsE);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    tests++;
    if (validE !== 1'b1 || rd1E !== 32'h0000_1234) begin
      fails++; $display("FAIL reset_first_edge: got valid=%b rd1=%h want 1/00001234", validE, rd1E);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({validE, rd1E, rd2E, signimmE, RsE, RtE, RdE, regwriteE, memtoregE, memwriteE,
         branchE, alusrcE, regdstE, alucontrolE} !== '0) begin
      fails++; $display("FAIL reset_async: outputs not zero, valid=%b rd1=%h", validE, rd1E);
    end
`ifdef ID_EX_PERF_CNT_EN
    tests++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      fails++; $display("FAIL reset_counters: stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_normal;
    drive_instr();
    tick();
    tests++;
    if (validE !== 1 || rd1E !== 32'h0000_1234 || rd2E !== 32'hA5A5_0001 || signimmE !== 32'hFFFF_FFF0) begin
      fails++; $display("FAIL normal_data: valid=%b rd1=%h rd2=%h imm=%h", validE, rd1E, rd2E, signimmE);
    end
    tests++;
    if (RsE !== 5'd3 || RtE !== 5'd4 || RdE !== 5'd5) begin
      fails++; $display("FAIL normal_regs: rs=%0d rt=%0d rd=%0d want 3/4/5", RsE, RtE, RdE);
    end
    tests++;
    if ({regwriteE, memtoregE, memwriteE, branchE, alusrcE, regdstE, alucontrolE} !== 9'b110011_010) begin
      fails++; $display("FAIL normal_ctrl: got %b want 110011010",
                        {regwriteE, memtoregE, memwriteE, branchE, alusrcE, regdstE, alucontrolE});
    end
  endtask

  task automatic test_stall;
    stallE = 1'b1;
    rd1D = 32'hFFFF_FFFF; RsD = 5'd31; validD = 1'b0; alucontrolD = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (rd1E !== 32'h0000_1234 || RsE !== 5'd3 || validE !== 1'b1 || alucontrolE !== 3'b010) begin
        fails++; $display("FAIL stall_hold[%0d]: rd1=%h rs=%0d valid=%b alu=%b", i, rd1E, RsE, validE, alucontrolE);
      end
    end
`ifdef ID_EX_PERF_CNT_EN
    tests++;
    if (stall_cnt !== 4'd3) begin
      fails++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_flush_stall;
    drive_instr();
    memwriteD = 1'b1;
    stallE = 1'b1; flushE = 1'b1;
    tick();
    tests++;
    if ({validE, rd1E, rd2E, signimmE, RsE, RtE, RdE, regwriteE, memtoregE, memwriteE,
         branchE, alusrcE, regdstE, alucontrolE} !== '0) begin
      fails++; $display("FAIL flush_over_stall: valid=%b rw=%b mw=%b rd1=%h", validE, regwriteE, memwriteE, rd1E);
    end
`ifdef ID_EX_PERF_CNT_EN
    tests++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd3) begin
      fails++; $display("FAIL flush_counts: flush=%0d stall=%0d want 1/3", flush_cnt, stall_cnt);
    end
`endif
    stallE = 1'b0; flushE = 1'b0;
  endtask

  task automatic test_bubble;
    drive_instr();
    validD = 1'b0; branchD = 1'b1; memwriteD = 1'b1; rd1D = 32'h0000_0077;
    tick();
    tests++;
    if (validE !== 0 || regwriteE !== 0 || branchE !== 0 || memwriteE !== 0) begin
      fails++; $display("FAIL bubble_gate: valid=%b rw=%b br=%b mw=%b want 0", validE, regwriteE, branchE, memwriteE);
    end
    tests++;
    if (alusrcE !== 1 || memtoregE !== 1 || rd1E !== 32'h0000_0077 || alucontrolE !== 3'b010) begin
      fails++; $display("FAIL bubble_capture: alusrc=%b m2r=%b rd1=%h alu=%b", alusrcE, memtoregE, rd1E, alucontrolE);
    end
  endtask

  task automatic test_back_to_back;
    drive_instr();
    tick();
    rd1D = 32'hDEAD_BEEF; RdD = 5'd17; alucontrolD = 3'b110;
    tick();
    tests++;
    if (rd1E !== 32'hDEAD_BEEF || RdE !== 5'd17 || alucontrolE !== 3'b110 || validE !== 1) begin
      fails++; $display("FAIL back_to_back: rd1=%h rd=%0d alu=%b valid=%b", rd1E, RdE, alucontrolE, validE);
    end
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_saturation;
    int exp;
    exp = 1;
    flushE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp < 15) exp++;
      tests++;
      if (flush_cnt !== exp[CNT_W-1:0]) begin
        fails++; $display("FAIL flush_sat[%0d]: got %0d want %0d", i, flush_cnt, exp);
      end
    end
    flushE = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_stall();
    stallE = 1'b0;
    test_flush_stall();
    test_bubble();
    test_back_to_back();
`ifdef ID_EX_PERF_CNT_EN
    test_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
